// File: rtl/block_dispatcher_rr_if.sv
// Launch/config and per-core control bundle for block_dispatcher_rr.
// start is a level request taken only while busy=0; per core, core_start holds high until core_done is seen high with it.
interface block_dispatcher_rr_if #(
  parameter int NUM_CORES      = 4,
  parameter int BLOCK_ID_WIDTH = 32
);
  logic                                          start;
  logic                                          abort;
  logic [BLOCK_ID_WIDTH-1:0]                     num_blocks;
  logic [NUM_CORES-1:0]                          core_enable;
  logic [NUM_CORES-1:0]                          core_done;
  logic [NUM_CORES-1:0]                          core_start;
  logic [NUM_CORES-1:0]                          core_reset;
  logic [NUM_CORES-1:0][BLOCK_ID_WIDTH-1:0]      core_block_id;
  logic [BLOCK_ID_WIDTH-1:0]                     blocks_done_count;
  logic                                          busy;
  logic                                          done;
  logic                                          aborted;

  modport master (
    output start, abort, num_blocks, core_enable, core_done,
    input  core_start, core_reset, core_block_id, blocks_done_count, busy, done, aborted
  );

  modport slave (
    input  start, abort, num_blocks, core_enable, core_done,
    output core_start, core_reset, core_block_id, blocks_done_count, busy, done, aborted
  );
endinterface

// File: rtl/block_dispatcher_rr.sv
// Round-robin thread-block dispatcher: hands block IDs to enabled, idle cores one per cycle
// and counts completions (several per cycle allowed) until the kernel drains or is aborted.
module block_dispatcher_rr #(
  parameter int NUM_CORES      = 4,
  parameter int BLOCK_ID_WIDTH = 32,
  parameter int RESET_CYCLES   = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  block_dispatcher_rr_if.slave  bus,
  output logic [1:0]            state_o
);
  localparam int PTR_W = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;
  localparam int CNT_W = $clog2(RESET_CYCLES + 1);

  typedef enum logic [1:0] {
    S_IDLE        = 2'd0,
    S_RESET_CORES = 2'd1,
    S_DISPATCH    = 2'd2,
    S_DRAIN       = 2'd3
  } state_e;

  state_e                                   state_q, state_d;
  logic [CNT_W-1:0]                         rst_cnt_q, rst_cnt_d;
  logic [BLOCK_ID_WIDTH-1:0]                num_blocks_q, num_blocks_d;
  logic [BLOCK_ID_WIDTH-1:0]                next_block_q, next_block_d;
  logic [BLOCK_ID_WIDTH-1:0]                done_count_q, done_count_d;
  logic [NUM_CORES-1:0]                     enable_q, enable_d;
  logic [NUM_CORES-1:0]                     core_start_q, core_start_d;
  logic [NUM_CORES-1:0]                     core_reset_q, core_reset_d;
  logic [NUM_CORES-1:0][BLOCK_ID_WIDTH-1:0] block_id_q, block_id_d;
  logic [PTR_W-1:0]                         rr_ptr_q, rr_ptr_d;
  logic                                     done_q, done_d;
  logic                                     aborted_q, aborted_d;

  logic [NUM_CORES-1:0]      ready;
  logic [NUM_CORES-1:0]      complete;
  logic                      pick_valid;
  logic [PTR_W-1:0]          pick_idx;
  logic [BLOCK_ID_WIDTH-1:0] comp_count;
  logic [BLOCK_ID_WIDTH-1:0] count_next;
  logic                      accept, launch_zero, launch_bad, abort_hit;
  logic                      last_dispatch, drain_done;

  // A core that completes this cycle still has core_start high, so it can never be picked here.
  assign ready    = enable_q & ~core_start_q & ~core_reset_q;
  assign complete = core_start_q & bus.core_done;

  always_comb begin
    int               idx;
    logic [PTR_W-1:0] idx_w;
    pick_valid = 1'b0;
    pick_idx   = '0;
    idx        = 0;
    idx_w      = '0;
    for (int j = 0; j < NUM_CORES; j++) begin
      idx = int'(rr_ptr_q) + j;
      if (idx >= NUM_CORES) idx = idx - NUM_CORES;
      idx_w = PTR_W'(idx);
      if (!pick_valid && ready[idx_w]) begin
        pick_valid = 1'b1;
        pick_idx   = idx_w;
      end
    end
  end

  always_comb begin
    comp_count = '0;
    for (int i = 0; i < NUM_CORES; i++) begin
      comp_count = comp_count + BLOCK_ID_WIDTH'(complete[i]);
    end
  end

  assign count_next    = done_count_q + comp_count;
  assign accept        = (state_q == S_IDLE) && bus.start;
  assign launch_zero   = (bus.num_blocks == '0);
  assign launch_bad    = !launch_zero && (bus.core_enable == '0);
  assign abort_hit     = (state_q != S_IDLE) && bus.abort;
  assign last_dispatch = pick_valid && ((next_block_q + 1'b1) == num_blocks_q);
  assign drain_done    = (count_next == num_blocks_q);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:        if (accept && !launch_zero && !launch_bad) state_d = S_RESET_CORES;
      S_RESET_CORES: if (abort_hit) state_d = S_IDLE;
                     else if (rst_cnt_q == '0) state_d = S_DISPATCH;
      S_DISPATCH:    if (abort_hit) state_d = S_IDLE;
                     else if (last_dispatch) state_d = S_DRAIN;
      S_DRAIN:       if (abort_hit || drain_done) state_d = S_IDLE;
      default:       state_d = S_IDLE;
    endcase
  end

  always_comb begin
    rst_cnt_d    = rst_cnt_q;
    num_blocks_d = num_blocks_q;
    next_block_d = next_block_q;
    done_count_d = done_count_q;
    enable_d     = enable_q;
    core_start_d = core_start_q;
    core_reset_d = core_reset_q;
    block_id_d   = block_id_q;
    rr_ptr_d     = rr_ptr_q;
    done_d       = done_q;
    aborted_d    = 1'b0;
    if (state_q == S_IDLE) begin
      core_start_d = '0;
      core_reset_d = '1;
      if (accept) begin
        num_blocks_d = bus.num_blocks;
        enable_d     = bus.core_enable;
        done_count_d = '0;
        next_block_d = '0;
        rr_ptr_d     = '0;
        rst_cnt_d    = CNT_W'(RESET_CYCLES);
        done_d       = launch_zero;
        aborted_d    = launch_bad;
      end
    end else if (abort_hit) begin
      core_start_d = '0;
      core_reset_d = '1;
      aborted_d    = 1'b1;
      done_d       = 1'b0;
    end else if (state_q == S_RESET_CORES) begin
      if (rst_cnt_q == '0) core_reset_d = ~enable_q;
      else                 rst_cnt_d    = rst_cnt_q - 1'b1;
    end else begin
      core_start_d = core_start_q & ~complete;
      done_count_d = count_next;
      if (state_q == S_DISPATCH) begin
        // Completing cores get a single reset cycle; disabled cores stay in reset.
        core_reset_d = ~enable_q | complete;
        if (pick_valid) begin
          core_start_d[pick_idx] = 1'b1;
          block_id_d[pick_idx]   = next_block_q;
          next_block_d           = next_block_q + 1'b1;
          rr_ptr_d = (int'(pick_idx) == NUM_CORES - 1) ? '0 : pick_idx + PTR_W'(1);
        end
      end else begin
        core_reset_d = ~core_start_d;
        if (drain_done) begin
          done_d       = 1'b1;
          core_reset_d = '1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rst_cnt_q    <= '0;
      num_blocks_q <= '0;
      next_block_q <= '0;
      done_count_q <= '0;
      enable_q     <= '0;
      core_start_q <= '0;
      core_reset_q <= '1;
      block_id_q   <= '0;
      rr_ptr_q     <= '0;
      done_q       <= 1'b0;
      aborted_q    <= 1'b0;
    end else begin
      rst_cnt_q    <= rst_cnt_d;
      num_blocks_q <= num_blocks_d;
      next_block_q <= next_block_d;
      done_count_q <= done_count_d;
      enable_q     <= enable_d;
      core_start_q <= core_start_d;
      core_reset_q <= core_reset_d;
      block_id_q   <= block_id_d;
      rr_ptr_q     <= rr_ptr_d;
      done_q       <= done_d;
      aborted_q    <= aborted_d;
    end
  end

  assign bus.core_start        = core_start_q;
  assign bus.core_reset        = core_reset_q;
  assign bus.core_block_id     = block_id_q;
  assign bus.blocks_done_count = done_count_q;
  assign bus.busy              = (state_q != S_IDLE);
  assign bus.done              = done_q;
  assign bus.aborted           = aborted_q;
  assign state_o               = state_q;
endmodule

// File: tb/tb_block_dispatcher_rr.sv
// Randomized bench for block_dispatcher_rr: a cycle-level behavioural model of the dispatch
// rules plus an ID scoreboard, compared against the DUT on every falling edge.
module tb_block_dispatcher_rr;
  localparam int NC = 4;
  localparam int W  = 32;
  localparam int RC = 2;
  localparam int M_FIXED   = 0;
  localparam int M_RANDOM  = 1;
  localparam int M_BARRIER = 2;

  logic       clk;
  logic       rst_n;
  logic [1:0] state_dbg;

  block_dispatcher_rr_if #(.NUM_CORES(NC), .BLOCK_ID_WIDTH(W)) bus ();

  block_dispatcher_rr #(.NUM_CORES(NC), .BLOCK_ID_WIDTH(W), .RESET_CYCLES(RC)) dut (
    .clk    (clk),
    .reset  (rst_n),
    .bus    (bus),
    .state_o(state_dbg)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // reference model: phase 0 idle, 1 core reset, 2 dispatching, 3 draining
  int         m_phase, m_left, m_ptr;
  logic [W-1:0]  m_num, m_next, m_cnt;
  logic [NC-1:0] m_en, m_run, m_rst;
  logic [W-1:0]  m_id [NC];
  bit         m_done, m_aborted;

  task automatic model_reset();
    m_phase = 0; m_left = 0; m_ptr = 0;
    m_num = '0; m_next = '0; m_cnt = '0;
    m_en = '0; m_run = '0; m_rst = '1;
    for (int i = 0; i < NC; i++) m_id[i] = '0;
    m_done = 0; m_aborted = 0;
  endtask

  task automatic model_step(input bit s, input bit a, input logic [W-1:0] nb,
                            input logic [NC-1:0] en, input logic [NC-1:0] dn);
    logic [NC-1:0] comp;
    int pick;
    m_aborted = 0;
    if (m_phase == 0) begin
      m_run = '0; m_rst = '1;
      if (s) begin
        m_num = nb; m_en = en; m_cnt = '0; m_next = '0; m_ptr = 0; m_done = 0;
        if (nb == 0) m_done = 1;
        else if (en == 0) m_aborted = 1;
        else begin m_phase = 1; m_left = RC + 1; end
      end
    end else if (a) begin
      m_run = '0; m_rst = '1; m_aborted = 1; m_done = 0; m_phase = 0;
    end else if (m_phase == 1) begin
      m_left--;
      if (m_left == 0) begin m_rst = ~m_en; m_phase = 2; end
    end else begin
      comp = m_run & dn;
      pick = -1;
      if (m_phase == 2) begin
        for (int j = 0; j < NC; j++) begin
          int c;
          c = (m_ptr + j) % NC;
          if (pick < 0 && m_en[c] && !m_run[c] && !m_rst[c]) pick = c;
        end
      end
      m_cnt = m_cnt + W'($countones(comp));
      m_run = m_run & ~comp;
      if (m_phase == 2) begin
        m_rst = ~m_en | comp;
        if (pick >= 0) begin
          m_run[pick] = 1'b1;
          m_id[pick]  = m_next;
          m_next      = m_next + 1;
          m_ptr       = (pick + 1) % NC;
          if (m_next == m_num) m_phase = 3;
        end
      end else begin
        m_rst = ~m_run;
        if (m_cnt == m_num) begin m_done = 1; m_phase = 0; m_rst = '1; end
      end
    end
  endtask

  // scoreboard and stimulus state
  logic [W-1:0]  exp_q [$];
  int            order_q [$];
  logic [W-1:0]  k_num;
  logic [NC-1:0] k_en;
  int            resp_mode;
  int            age [NC];
  int            lat [NC];
  logic [NC-1:0] prev_start;
  logic [W-1:0]  prev_cnt;
  int            max_step;
  int            cyc, launch_cyc;
  bit            track_ids, first_pending;

  task automatic check_outputs();
    check("core_start", 64'(bus.core_start), 64'(m_run));
    check("core_reset", 64'(bus.core_reset), 64'(m_rst));
    for (int i = 0; i < NC; i++) check($sformatf("block_id%0d", i), 64'(bus.core_block_id[i]), 64'(m_id[i]));
    check("blocks_done_count", 64'(bus.blocks_done_count), 64'(m_cnt));
    check("busy", 64'(bus.busy), 64'(m_phase != 0));
    check("done", 64'(bus.done), 64'(m_done));
    check("aborted", 64'(bus.aborted), 64'(m_aborted));
  endtask

  task automatic scoreboard();
    bit found;
    for (int i = 0; i < NC; i++) begin
      if (bus.core_start[i] && !prev_start[i]) begin
        order_q.push_back(i);
        if (first_pending) begin
          check("first_dispatch_edge", 64'(cyc - launch_cyc), 64'(RC + 2));
          first_pending = 0;
        end
        if (track_ids) begin
          found = 0;
          for (int q = 0; q < exp_q.size(); q++) begin
            if (!found && exp_q[q] == bus.core_block_id[i]) begin
              exp_q.delete(q);
              found = 1;
            end
          end
          check("dispatch_id_unique", 64'(found), 64'(1));
        end
      end
    end
    if (bus.blocks_done_count > prev_cnt && int'(bus.blocks_done_count - prev_cnt) > max_step)
      max_step = int'(bus.blocks_done_count - prev_cnt);
    prev_cnt   = bus.blocks_done_count;
    prev_start = bus.core_start;
  endtask

  // driver: one clock of stimulus, model update, then compare after the edge
  task automatic cycle(input bit s, input bit a);
    logic [NC-1:0] dn;
    bit st;
    st = s;
    if (!s && m_phase != 0) st = ($urandom_range(0, 3) == 0);
    bus.start = st;
    bus.abort = a;
    if (s) begin
      bus.num_blocks  = k_num;
      bus.core_enable = k_en;
    end else begin
      bus.num_blocks  = $urandom;
      bus.core_enable = NC'($urandom);
    end
    for (int i = 0; i < NC; i++) begin
      if (bus.core_start[i]) begin
        age[i]++;
        if (age[i] == 1) lat[i] = (resp_mode == M_RANDOM) ? int'($urandom_range(1, 5)) : 3;
      end else begin
        age[i] = 0;
      end
      if (resp_mode == M_BARRIER) dn[i] = &bus.core_start;
      else dn[i] = bus.core_start[i] && (age[i] >= lat[i]);
      if (resp_mode == M_RANDOM && !bus.core_start[i]) dn[i] = 1'($urandom_range(0, 1));
    end
    bus.core_done = dn;
    if (s && m_phase == 0 && k_num != 0 && k_en != 0) begin
      exp_q.delete();
      order_q.delete();
      track_ids = (k_num <= 256);
      if (track_ids) for (int b = 0; b < int'(k_num); b++) exp_q.push_back(W'(b));
      launch_cyc    = cyc;
      first_pending = 1;
    end
    if (a && m_phase != 0) begin
      exp_q.delete();
      track_ids = 0;
    end
    model_step(st, a, bus.num_blocks, bus.core_enable, dn);
    @(negedge clk);
    check_outputs();
    scoreboard();
    cyc++;
  endtask

  task automatic run_kernel(input logic [W-1:0] n, input logic [NC-1:0] en, input int mode,
                            input logic [W-1:0] abort_at, input int stop_after);
    int budget;
    bit ab_sent;
    bit a;
    k_num = n; k_en = en; resp_mode = mode; max_step = 0;
    track_ids = 0;
    cycle(1, 0);
    budget  = 0;
    ab_sent = 0;
    while (m_phase != 0 && budget < 1500) begin
      a = 0;
      if (!ab_sent && abort_at != 0 && m_next >= abort_at) begin a = 1; ab_sent = 1; end
      cycle(0, a);
      budget++;
      if (stop_after != 0 && budget >= stop_after) return;
    end
    if (m_phase != 0) check("kernel_timeout", 64'(0), 64'(1));
    if (track_ids && !ab_sent) check("ids_all_dispatched", 64'(exp_q.size()), 64'(0));
    cycle(0, 0);
  endtask

  initial begin
    logic [W-1:0]  rn, ra;
    logic [NC-1:0] re;
    rst_n = 1'b1;
    bus.start = 0; bus.abort = 0; bus.num_blocks = '0; bus.core_enable = '0; bus.core_done = '0;
    for (int i = 0; i < NC; i++) begin age[i] = 0; lat[i] = 3; end
    cyc = 0; launch_cyc = 0; track_ids = 0; first_pending = 0; max_step = 0;
    prev_start = '0; prev_cnt = '0;
    model_reset();
    #2 rst_n = 1'b0;
    @(negedge clk);
    check_outputs();
    rst_n = 1'b1;

    // 10 blocks on 4 cores, fixed 3-cycle latency
    run_kernel(10, 4'b1111, M_FIXED, 0, 0);
    for (int i = 0; i < 4; i++) check($sformatf("rr_order%0d", i), 64'(order_q[i]), 64'(i));
    check("count_after_10", 64'(bus.blocks_done_count), 64'(10));
    check("done_after_10", 64'(bus.done), 64'(1));

    // empty kernel
    run_kernel(0, 4'b1111, M_FIXED, 0, 0);
    check("zero_kernel_done", 64'(bus.done), 64'(1));

    // all four cores complete in the same cycle
    run_kernel(8, 4'b1111, M_BARRIER, 0, 0);
    check("simultaneous_step", 64'(max_step), 64'(4));

    // partial core mask
    run_kernel(5, 4'b0101, M_RANDOM, 0, 0);
    check("masked_count", 64'(bus.blocks_done_count), 64'(5));

    // abort after three dispatches, then a normal launch
    run_kernel(8, 4'b1111, M_FIXED, 3, 0);
    check("abort_done_low", 64'(bus.done), 64'(0));
    run_kernel(4, 4'b1111, M_FIXED, 0, 0);
    check("relaunch_count", 64'(bus.blocks_done_count), 64'(4));

    // invalid launch: no enabled cores
    run_kernel(3, 4'b0000, M_FIXED, 0, 0);

    // maximum block count, aborted early
    run_kernel(32'hFFFF_FFFF, 4'b1111, M_RANDOM, 6, 0);

    for (int t = 0; t < 10; t++) begin
      rn = W'($urandom_range(1, 24));
      re = NC'($urandom_range(0, 15));
      ra = ($urandom_range(0, 3) == 0) ? W'($urandom_range(1, int'(rn))) : '0;
      run_kernel(rn, re, M_RANDOM, ra, 0);
    end

    // asynchronous reset in the middle of dispatch
    run_kernel(20, 4'b1111, M_FIXED, 0, 12);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    exp_q.delete(); track_ids = 0; first_pending = 0;
    check_outputs();
    bus.start = 1'b1; bus.num_blocks = 5; bus.core_enable = '1;
    @(posedge clk);
    #1;
    check("start_in_reset_busy", 64'(bus.busy), 64'(0));
    check_outputs();
    @(negedge clk);
    bus.start = 1'b0;
    rst_n = 1'b1;
    prev_start = bus.core_start;
    prev_cnt   = bus.blocks_done_count;
    run_kernel(6, 4'b1111, M_RANDOM, 0, 0);
    check("post_reset_count", 64'(bus.blocks_done_count), 64'(6));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/block_dispatcher_rr.md
Name: block_dispatcher_rr

Overview:
Next-generation kernel block dispatcher. It distributes num_blocks thread-block IDs across a parametrised core array using round-robin core selection, a per-kernel core-enable mask, and abort support. Simultaneous completions are counted exactly. It sits between the kernel launch/config registers and the compute cores, and drives each core's start, reset and block ID.

Parameters:
NUM_CORES, 4, number of compute cores (1..32).
BLOCK_ID_WIDTH, 32, width of block IDs and block counts.
RESET_CYCLES, 1, cycles core_reset is held for enabled cores at kernel launch (>=1).

Ports:
clk  in  1  clock; all logic on rising edge.
reset  in  1  one clock; reset is asynchronous and active-low.
start  in  1  launch request; sampled only in IDLE.
abort  in  1  cancel running kernel; ignored in IDLE.
num_blocks  in  BLOCK_ID_WIDTH  blocks in the kernel; latched on accepted start.
core_enable  in  NUM_CORES  cores usable by this kernel; latched on accepted start.
core_done  in  NUM_CORES  per-core block-complete level.
core_start  out  NUM_CORES  per-core run request, held until completion.
core_reset  out  NUM_CORES  per-core reset.
core_block_id  out  NUM_CORES x BLOCK_ID_WIDTH  block ID assigned to each core.
blocks_done_count  out  BLOCK_ID_WIDTH  completed blocks in the current kernel.
busy  out  1  high in any state other than IDLE.
done  out  1  kernel completed; sticky until the next accepted start or reset.
aborted  out  1  one-cycle pulse on abort or an invalid launch.

Behaviour:
- Reset (reset low, asynchronous): state=IDLE. core_start=0, core_reset=all 1, core_block_id=0, blocks_done_count=0, done=0, aborted=0, busy=0, rr_ptr=0, next_block=0.
- States: IDLE, RESET_CORES, DISPATCH, DRAIN.
- IDLE:
  - start=1 accepted: latch num_blocks and core_enable; clear done, blocks_done_count and next_block; rr_ptr=0.
  - num_blocks==0: done=1 at the next edge, stay IDLE.
  - num_blocks>0 and core_enable==0: aborted pulse, stay IDLE.
  - Otherwise: enter RESET_CORES, core_reset=1 on all cores for RESET_CYCLES cycles.
- Disabled cores (latched mask bit 0): core_reset held 1 and core_start held 0 for the whole kernel.
- Core ready = enabled && !core_start && !core_reset.
- RESET_CORES: after RESET_CYCLES cycles, deassert core_reset on enabled cores and enter DISPATCH. With start accepted at edge k, the first core_start rises at edge k+RESET_CYCLES+2.
- DISPATCH: at most one dispatch per cycle.
  - Select the first ready core searching circularly from rr_ptr.
  - Set core_start[i]=1 and core_block_id[i]=next_block; increment next_block; rr_ptr=(i+1) mod NUM_CORES.
  - When next_block reaches num_blocks, enter DRAIN.
- Completion, in DISPATCH and DRAIN:
  - A core completes when core_start[i] && core_done[i].
  - Next edge: core_start[i]=0 and core_reset[i]=1 for exactly one cycle; the core is ready again the cycle after.
  - A core is never re-dispatched in the same cycle it completes.
  - blocks_done_count increments by the popcount of completions in that cycle (all simultaneous completions counted).
  - core_done on a non-started or disabled core is ignored.
  - core_block_id holds its value after completion.
- DRAIN: when blocks_done_count equals the latched num_blocks (including the same-edge update), set done=1 and enter IDLE. Idle enabled cores hold core_reset=1.
- abort in RESET_CORES, DISPATCH or DRAIN: next edge sets core_start=0, core_reset=all 1, aborted pulse, done=0, state=IDLE. blocks_done_count holds its value.
- start while busy is ignored. num_blocks and core_enable changes after launch have no effect.
- Counts use BLOCK_ID_WIDTH unsigned arithmetic. num_blocks up to 2^BLOCK_ID_WIDTH-1 is supported without wrap.
- Async reset mid-kernel: immediate return to reset values; no partial state survives.

Test Plan:
- NUM_CORES=4, num_blocks=10, all enabled, each core asserts core_done 3 cycles after its core_start -> IDs 0..9 each dispatched exactly once; first four dispatches go to cores 0,1,2,3 in order; done=1 after the 10th completion; blocks_done_count=10.
- num_blocks=0, start pulse at edge k -> done=1 at k+1; core_start never asserted; busy stays 0.
- 4 cores running blocks 0..3 all assert core_done in the same cycle -> blocks_done_count steps by 4 in one edge; each core_reset pulses high for exactly one cycle.
- core_enable=4'b0101, num_blocks=5 -> only cores 0 and 2 receive core_start; cores 1 and 3 keep core_reset=1 and core_start=0 throughout; done after 5 completions.
- abort asserted after 3 of 8 blocks dispatched -> next edge: core_start=0, core_reset=4'b1111, aborted single-cycle pulse, done=0, busy=0; a new start is then accepted normally.
- reset driven low mid-DISPATCH between clock edges -> outputs take reset values immediately; start held high while reset is low is ignored.
